// File: rtl/axi_xbar_pkg.sv
// Shared constants for the AXI crossbar slice.
//   ID_W / ADDR_W / LEN_W / SIZE_W : default AxID / AxADDR / AxLEN / AxSIZE widths
//   BURST_W                        : AxBURST width
//   BURST_FIXED / _INCR / _WRAP    : AxBURST encodings
package axi_xbar_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_ax_fifo_ctrl.sv
// ax_fifo_ctrl: pointer / occupancy bookkeeping for axi_ax_fifo.
// Works for any DEPTH >= 2; pointers wrap explicitly at DEPTH-1.
// Ports:
//   ACLK     in   clock, rising edge
//   ARESET   in   synchronous reset, active-high
//   push     in   write one entry at wr_ptr (ignored when full)
//   pop      in   retire the entry at rd_ptr (ignored when empty)
//   wr_ptr   out  next slot to write
//   rd_ptr   out  current head slot
//   count    out  occupancy 0..DEPTH
//   full     out  registered, count == DEPTH
//   empty    out  registered, count == 0
module ax_fifo_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic          push_ok;
  logic          pop_ok;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;

  always_comb begin
    push_ok    = push & ~full;
    pop_ok     = pop & ~empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (push_ok) wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    if (pop_ok)  rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are registered from the next count so s_ready (= !full) never
  // depends combinationally on this cycle's pop.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == DEPTH_C);
      empty  <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/axi_ax_fifo.sv
// axi_ax_fifo: pending-request FIFO for an AXI AR or AW channel, placed
// between a master address port and the crossbar arbiter/decoder.
// Holds up to DEPTH requests (any DEPTH >= 2), in order, payload untouched.
// Optional build macro AX_FIFO_BYPASS_EN: when empty, an incoming request is
// presented on m_* in the same cycle and skips storage if accepted at once.
// Ports:
//   ACLK, ARESET                   clock / synchronous active-high reset
//   s_axid/axaddr/axlen/axsize/axburst, s_valid, s_ready   upstream request
//   m_axid/axaddr/axlen/axsize/axburst, m_valid, m_ready   head request
//   count                          occupancy 0..DEPTH
//   almost_full                    count >= AFULL_THRESH
//   full / empty                   count == DEPTH / count == 0
module axi_ax_fifo
  import axi_xbar_pkg::*;
#(
  parameter  int ID_WIDTH     = ID_W,
  parameter  int ADDR_WIDTH   = ADDR_W,
  parameter  int LEN_WIDTH    = LEN_W,
  parameter  int SIZE_WIDTH   = SIZE_W,
  parameter  int DEPTH        = 4,
  parameter  int AFULL_THRESH = 3,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_WIDTH-1:0]   s_axid,
  input  logic [ADDR_WIDTH-1:0] s_axaddr,
  input  logic [LEN_WIDTH-1:0]  s_axlen,
  input  logic [SIZE_WIDTH-1:0] s_axsize,
  input  logic [BURST_W-1:0]    s_axburst,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ID_WIDTH-1:0]   m_axid,
  output logic [ADDR_WIDTH-1:0] m_axaddr,
  output logic [LEN_WIDTH-1:0]  m_axlen,
  output logic [SIZE_WIDTH-1:0] m_axsize,
  output logic [BURST_W-1:0]    m_axburst,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  full,
  output logic                  empty
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            PLW  = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_W;
  localparam logic [CW-1:0] AF_C = CW'(AFULL_THRESH);

  logic [PLW-1:0] mem [DEPTH];
  logic [PLW-1:0] wr_data;
  logic [PLW-1:0] head;
  logic [PLW-1:0] m_payload;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           pass_through;
  logic           push;
  logic           pop;

  assign wr_data = {s_axid, s_axaddr, s_axlen, s_axsize, s_axburst};
  assign head    = mem[rd_ptr];

`ifdef AX_FIFO_BYPASS_EN
  logic bypass;
  assign bypass       = empty & s_valid;
  assign m_valid      = ~empty | s_valid;
  assign m_payload    = bypass ? wr_data : head;
  // Accepted in the same cycle it arrived: neither stored nor counted.
  assign pass_through = bypass & m_ready;
`else
  assign m_valid      = ~empty;
  assign m_payload    = head;
  assign pass_through = 1'b0;
`endif

  assign {m_axid, m_axaddr, m_axlen, m_axsize, m_axburst} = m_payload;

  assign s_ready     = ~full;
  assign push        = s_valid & s_ready & ~pass_through;
  assign pop         = m_valid & m_ready & ~pass_through;
  assign almost_full = (count >= AF_C);

  ax_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge ACLK) begin
    if (push && !ARESET) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_axi_ax_fifo.sv
module tb_axi_ax_fifo;
  import axi_xbar_pkg::*;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESET;

  // DEPTH=4 instance
  logic [3:0]  s_axid;
  logic [31:0] s_axaddr;
  logic [3:0]  s_axlen;
  logic [2:0]  s_axsize;
  logic [1:0]  s_axburst;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [3:0]  m_axid;
  logic [31:0] m_axaddr;
  logic [3:0]  m_axlen;
  logic [2:0]  m_axsize;
  logic [1:0]  m_axburst;
  logic [2:0]  count;
  logic        almost_full, full, empty;

  // DEPTH=3 instance
  logic [3:0]  a_id;
  logic [31:0] a_addr;
  logic [3:0]  a_len;
  logic [2:0]  a_size;
  logic [1:0]  a_burst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [3:0]  b_id;
  logic [31:0] b_addr;
  logic [3:0]  b_len;
  logic [2:0]  b_size;
  logic [1:0]  b_burst;
  logic [1:0]  count3;
  logic        af3, full3, empty3;

  axi_ax_fifo #(.DEPTH(4), .AFULL_THRESH(3)) dut4 (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axid(s_axid), .s_axaddr(s_axaddr), .s_axlen(s_axlen), .s_axsize(s_axsize),
    .s_axburst(s_axburst), .s_valid(s_valid), .s_ready(s_ready),
    .m_axid(m_axid), .m_axaddr(m_axaddr), .m_axlen(m_axlen), .m_axsize(m_axsize),
    .m_axburst(m_axburst), .m_valid(m_valid), .m_ready(m_ready),
    .count(count), .almost_full(almost_full), .full(full), .empty(empty)
  );

  axi_ax_fifo #(.DEPTH(3), .AFULL_THRESH(2)) dut3 (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axid(a_id), .s_axaddr(a_addr), .s_axlen(a_len), .s_axsize(a_size),
    .s_axburst(a_burst), .s_valid(a_valid), .s_ready(a_ready),
    .m_axid(b_id), .m_axaddr(b_addr), .m_axlen(b_len), .m_axsize(b_size),
    .m_axburst(b_burst), .m_valid(b_valid), .m_ready(b_ready),
    .count(count3), .almost_full(af3), .full(full3), .empty(empty3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic       sv;
    logic [3:0] id;
    logic       mr;
    logic       e_sready;
    logic       e_mvalid;
    logic [3:0] e_id;
    logic       chk_id;
    logic [2:0] e_cnt;
    logic       e_full;
    logic       e_empty;
    logic       e_af;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    //          sv  id    mr  srdy mval e_id chk cnt  full emp af
    tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

    ARESET = 1'b1;
    s_valid = 0; s_axid = 0; s_axaddr = 0; s_axlen = 0; s_axsize = 0; s_axburst = 0; m_ready = 0;
    a_valid = 0; a_id = 0; a_addr = 0; a_len = 0; a_size = 0; a_burst = 0; b_ready = 0;

    // Reset held two cycles
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst3_count", count3, 0);
    chk("rst3_empty", empty3, 1);

    // Fill to full, refused 5th push, pop while full, drain in order
    for (int i = 0; i < 9; i++) begin
      s_valid  = tbl[i].sv;
      s_axid   = tbl[i].id;
      s_axaddr = 32'h100 * tbl[i].id;
      m_ready  = tbl[i].mr;
      step();
      chk($sformatf("v%0d_s_ready", i), s_ready, tbl[i].e_sready);
      chk($sformatf("v%0d_m_valid", i), m_valid, tbl[i].e_mvalid);
      chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e_empty);
      chk($sformatf("v%0d_afull", i), almost_full, tbl[i].e_af);
      if (tbl[i].chk_id) begin
        chk($sformatf("v%0d_m_axid", i), m_axid, tbl[i].e_id);
        chk($sformatf("v%0d_m_axaddr", i), m_axaddr, 32'h100 * tbl[i].e_id);
      end
    end
    s_valid = 0; m_ready = 0;

    // Reset mid-traffic discards entries; no push taken on the reset cycle
    s_valid = 1; s_axid = 4'hA; step();
    s_axid = 4'hB; step();
    chk("mid_pre_count", count, 2);
    ARESET = 1; s_axid = 4'hC; m_ready = 1; step();
    ARESET = 0; s_valid = 0; m_ready = 0; #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 1);

    // DEPTH=3 wrap: ten push/pop pairs at steady count=1
    a_valid = 1; a_addr = 32'h1000; b_ready = 0; step();
    chk("wrap_first_count", count3, 1);
    for (int i = 1; i <= 10; i++) begin
      a_addr = 32'h1000 + 4 * i; b_ready = 1; #1;
      chk($sformatf("wrap%0d_head", i), b_addr, 32'h1000 + 4 * (i - 1));
      chk($sformatf("wrap%0d_valid", i), b_valid, 1);
      step();
      chk($sformatf("wrap%0d_count", i), count3, 1);
    end
    a_valid = 0; #1;
    chk("wrap_last_head", b_addr, 32'h1028);
    step();
    chk("wrap_drained", empty3, 1);
    b_ready = 0;

    // Stall: head held stable while m_ready is low, even as a second entry queues
    s_valid = 1; s_axid = 4'd9; s_axaddr = 32'hDEAD_BEEF;
    s_axlen = 4'd5; s_axsize = 3'd2; s_axburst = BURST_INCR; m_ready = 0;
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        s_axid = 4'd6; s_axaddr = 32'h1234; s_axlen = 4'd0; s_axsize = 3'd0; s_axburst = BURST_WRAP;
      end else s_valid = 0;
      step();
      chk($sformatf("stall%0d_addr", c), m_axaddr, 32'hDEAD_BEEF);
      chk($sformatf("stall%0d_id", c), m_axid, 9);
      chk($sformatf("stall%0d_valid", c), m_valid, 1);
    end
    chk("stall_len", m_axlen, 5);
    chk("stall_size", m_axsize, 2);
    chk("stall_burst", m_axburst, BURST_INCR);
    chk("stall_count", count, 2);
    m_ready = 1; step();
    chk("stall_next_addr", m_axaddr, 32'h1234);
    chk("stall_next_burst", m_axburst, BURST_WRAP);
    step();
    chk("stall_drained", empty, 1);
    m_ready = 0;

    // Bypass (or one-cycle latency without it) from empty
    s_valid = 1; s_axid = 4'd7; s_axaddr = 32'h77; m_ready = 1; #1;
`ifdef AX_FIFO_BYPASS_EN
    chk("byp_same_valid", m_valid, 1);
    chk("byp_same_id", m_axid, 7);
`else
    chk("byp_same_valid", m_valid, 0);
`endif
    step();
    s_valid = 0; m_ready = 0; #1;
`ifdef AX_FIFO_BYPASS_EN
    chk("byp_count", count, 0);
    chk("byp_after_valid", m_valid, 0);
`else
    chk("byp_count", count, 1);
    chk("byp_after_valid", m_valid, 1);
    chk("byp_after_id", m_axid, 7);
    m_ready = 1; step(); m_ready = 0;
    chk("byp_drained", empty, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
